// File: rtl/risc_v_fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/next-PC, imem handshake, IF/ID feed, redirect/stall arbitration.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module risc_v_fetch_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned PERF_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  pc_in,
   output logic                   pc_en,
   output logic [ADDR_WIDTH-1:0]  next_pc,
   output logic                   imem_req,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_target,
   output logic                   if_id_en,
   output logic                   if_id_flush,
   output logic [INSTR_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0]  if_pc,
   output logic [PERF_WIDTH-1:0]  perf_stall_cycles,
   output logic [PERF_WIDTH-1:0]  perf_redirects
);

   localparam logic [ADDR_WIDTH-1:0] WORD_INC   = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_e;

   state_e                 state_q, state_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [ADDR_WIDTH-1:0]  pend_target_q, pend_target_d;
   logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
   logic [ADDR_WIDTH-1:0]  buf_pc_q, buf_pc_d;

   logic                   redir_any;
   logic [ADDR_WIDTH-1:0]  redir_tgt;
   logic [ADDR_WIDTH-1:0]  next_pc_raw;

   assign redir_any = redirect_valid | pend_valid_q;
   assign redir_tgt = redirect_valid ? redirect_target : pend_target_q;
   assign next_pc   = next_pc_raw & ALIGN_MASK;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_BOOT;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         buf_instr_q   <= '0;
         buf_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         buf_instr_q   <= buf_instr_d;
         buf_pc_q      <= buf_pc_d;
      end
   end

   // Next state and all fetch-side outputs
   always_comb begin
      state_d       = state_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      buf_instr_d   = buf_instr_q;
      buf_pc_d      = buf_pc_q;
      pc_en         = 1'b0;
      next_pc_raw   = pc_in + WORD_INC;
      imem_req      = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      if_instr      = imem_rdata;
      if_pc         = pc_in;

      unique case (state_q)
         S_BOOT: begin
            if_id_flush = 1'b1;
            if_instr    = '0;
            if_pc       = '0;
            state_d     = S_REQ;
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (redir_any) begin
                  pc_en        = 1'b1;
                  next_pc_raw  = redir_tgt;
                  if_id_en     = 1'b1;
                  if_id_flush  = 1'b1;
                  pend_valid_d = 1'b0;
               end else if (stall) begin
                  buf_instr_d = imem_rdata;
                  buf_pc_d    = pc_in;
                  state_d     = S_HOLD;
               end else begin
                  pc_en    = 1'b1;
                  if_id_en = 1'b1;
               end
            end else begin
               // Address stays put mid-request; a redirect is parked until the ack.
               if (redirect_valid) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = redirect_target;
               end
               if (!stall) begin
                  if_id_en    = 1'b1;
                  if_id_flush = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if_instr = buf_instr_q;
            if_pc    = buf_pc_q;
            if (redir_any) begin
               pc_en        = 1'b1;
               next_pc_raw  = redir_tgt;
               if_id_en     = 1'b1;
               if_id_flush  = 1'b1;
               pend_valid_d = 1'b0;
               state_d      = S_REQ;
            end else if (!stall) begin
               pc_en       = 1'b1;
               next_pc_raw = buf_pc_q + WORD_INC;
               if_id_en    = 1'b1;
               state_d     = S_REQ;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

`ifdef FETCH_PERF_CNT_EN
   logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_WIDTH-1:0] redir_cnt_q, redir_cnt_d;
   logic                  redir_load_c;

   // A redirect is accepted exactly when the PC loads while one is live or pending
   assign redir_load_c = pc_en & redir_any;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if ((state_q != S_BOOT) && !if_id_en && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
      if (redir_load_c && (redir_cnt_q != '1))
         redir_cnt_d = redir_cnt_q + PERF_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_redirects    = redir_cnt_q;
`else
   assign perf_stall_cycles = '0;
   assign perf_redirects    = '0;
`endif

endmodule

// File: tb/tb_risc_v_fetch_ctrl.sv
// Bench for risc_v_fetch_ctrl: directed scenarios plus random traffic against a fetch-pipeline model.
module tb_risc_v_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_in = '0;
   logic        pc_en;
   logic [31:0] next_pc;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        if_id_en;
   logic        if_id_flush;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [15:0] perf_stall_cycles;
   logic [15:0] perf_redirects;

   risc_v_fetch_ctrl dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_en(pc_en), .next_pc(next_pc),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .if_id_en(if_id_en), .if_id_flush(if_id_flush), .if_instr(if_instr), .if_pc(if_pc),
      .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: is the fetch unit booting, waiting on memory, or holding a fetched word?
   bit          m_booting = 1'b1;
   bit          m_holding = 1'b0;
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_tgt = '0;
   logic [31:0] m_held_instr = '0;
   logic [31:0] m_held_pc = '0;
   logic [31:0] pc_reg = '0;
   int unsigned m_stall_cnt = 0;
   int unsigned m_redir_cnt = 0;

   // One clock: drive inputs, predict and compare outputs, then advance the model.
   task automatic step(input bit rst_n, input bit ack, input bit st, input bit rv,
                       input logic [31:0] rt, input logic [31:0] rd);
      bit          e_pc_en, e_req, e_en, e_flush, e_chk, e_boot, e_redir_acc;
      logic [31:0] e_next, e_instr, e_pc;
      bit          want_redir;
      logic [31:0] redir_to;
      @(negedge clk);
      reset = rst_n; imem_ack = ack; stall = st; redirect_valid = rv;
      redirect_target = rt; imem_rdata = rd; pc_in = pc_reg;
      #1;
      e_pc_en = 0; e_req = 0; e_en = 0; e_flush = 0; e_chk = 0; e_redir_acc = 0;
      e_next = '0; e_instr = '0; e_pc = '0;
      e_boot = !rst_n || m_booting;
      want_redir = rv || m_pend;
      redir_to = (rv ? rt : m_pend_tgt) & 32'hFFFF_FFFC;
      if (e_boot) begin
         e_flush = 1; e_chk = 1;
      end else if (m_holding) begin
         e_chk = 1; e_instr = m_held_instr; e_pc = m_held_pc;
         if (want_redir) begin
            e_pc_en = 1; e_next = redir_to; e_en = 1; e_flush = 1; e_redir_acc = 1;
         end else if (!st) begin
            e_pc_en = 1; e_next = m_held_pc + 32'd4; e_en = 1;
         end
      end else begin
         e_req = 1;
         if (ack && want_redir) begin
            e_pc_en = 1; e_next = redir_to; e_en = 1; e_flush = 1; e_redir_acc = 1;
         end else if (ack && !st) begin
            e_pc_en = 1; e_next = (pc_reg + 32'd4) & 32'hFFFF_FFFC;
            e_en = 1; e_chk = 1; e_instr = rd; e_pc = pc_reg;
         end else if (!ack && !st) begin
            e_en = 1; e_flush = 1;
         end
      end
      check_eq("pc_en", 32'(pc_en), 32'(e_pc_en));
      check_eq("imem_req", 32'(imem_req), 32'(e_req));
      check_eq("if_id_en", 32'(if_id_en), 32'(e_en));
      if (e_pc_en) check_eq("next_pc", next_pc, e_next);
      if (e_en || e_boot) check_eq("if_id_flush", 32'(if_id_flush), 32'(e_flush));
      if (e_chk) begin
         check_eq("if_instr", if_instr, e_instr);
         check_eq("if_pc", if_pc, e_pc);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_booting = 1; m_holding = 0; m_pend = 0; m_held_instr = '0; m_held_pc = '0;
         m_stall_cnt = 0; m_redir_cnt = 0; pc_reg = '0;
      end else begin
         if (!e_boot && !e_en && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
         if (e_redir_acc && m_redir_cnt < 16'hFFFF) m_redir_cnt++;
         if (e_pc_en) pc_reg = e_next;
         if (m_booting) m_booting = 0;
         else if (m_holding) begin
            if (want_redir || !st) m_holding = 0;
            if (want_redir) m_pend = 0;
         end else if (ack) begin
            if (want_redir) m_pend = 0;
            else if (st) begin
               m_holding = 1; m_held_instr = rd; m_held_pc = pc_reg;
            end
         end else if (rv) begin
            m_pend = 1; m_pend_tgt = rt;
         end
      end
      #1;
`ifdef FETCH_PERF_CNT_EN
      check_eq("perf_stall_cycles", 32'(perf_stall_cycles), m_stall_cnt);
      check_eq("perf_redirects", 32'(perf_redirects), m_redir_cnt);
`else
      check_eq("perf_stall_cycles", 32'(perf_stall_cycles), 32'd0);
      check_eq("perf_redirects", 32'(perf_redirects), 32'd0);
`endif
   endtask

   initial begin
      // Reset, one BOOT cycle, then zero-wait sequential fetch
      step(0, 0, 0, 0, '0, '0);
      step(0, 1, 0, 0, '0, 32'h1111);
      step(1, 1, 0, 0, '0, 32'h2222);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, '0, 32'h0000_0013 + 32'(i) * 32'h100);
      check_eq("seq_pc_after_4", pc_reg, 32'h10);

      // Three-cycle memory latency
      pc_reg = 32'h10;
      step(1, 0, 0, 0, '0, '0);
      step(1, 0, 0, 0, '0, '0);
      step(1, 1, 0, 0, '0, 32'hABCD_0001);
      check_eq("wait_pc", pc_reg, 32'h14);

      // Stall on ack, two held cycles, then release the buffered word
      pc_reg = 32'h20;
      step(1, 1, 1, 0, '0, 32'h0050_0093);
      step(1, 0, 1, 0, '0, 32'hDEAD_BEEF);
      step(1, 0, 0, 0, '0, 32'hDEAD_BEEF);
      check_eq("hold_release_pc", pc_reg, 32'h24);

      // Redirect parked during a wait, applied on the late ack
      pc_reg = 32'h40;
      step(1, 0, 0, 1, 32'h100, '0);
      step(1, 1, 0, 0, '0, 32'h5555);
      check_eq("pending_redirect_pc", pc_reg, 32'h100);
      step(1, 1, 0, 0, '0, 32'h6666);
      check_eq("pending_cleared_pc", pc_reg, 32'h104);

      // Unaligned redirect beating a stall while holding
      pc_reg = 32'h80;
      step(1, 1, 1, 0, '0, 32'h7777);
      step(1, 0, 1, 1, 32'h203, '0);
      check_eq("hold_redirect_pc", pc_reg, 32'h200);
      step(1, 1, 0, 0, '0, 32'h8888);

      // Reset mid-wait with a parked redirect; acks during reset are ignored
      pc_reg = 32'h300;
      step(1, 0, 0, 1, 32'h400, '0);
      step(0, 1, 0, 0, '0, 32'h9999);
      step(0, 1, 0, 0, '0, 32'h9999);
      step(1, 1, 0, 0, '0, 32'h9999);
      step(1, 1, 0, 0, '0, 32'hAAAA);
      check_eq("post_reset_pc", pc_reg, 32'h4);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0),
              $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
